// File: rtl/sparc_ifu_thr_pipe_trk_if.sv
// Bundle between the IFU LRU thread scheduler/core side (master) and the
// thread pipe tracker (slave) that produces the scheduler's request vectors.
interface sparc_ifu_thr_pipe_trk_if;
    logic [3:0] grant_vec;
    logic       pipe_stall;
    logic [3:0] flush_vec;
    logic       rollback_e;
    logic [3:0] thr_start;
    logic [3:0] thr_stop;
    logic       ll_spec_e;
    logic       ll_nospec_e;
    logic [3:0] spec_hit_vec;
    logic [3:0] spec_miss_vec;
    logic [3:0] done_vec;
    logic [3:0] req_vec;
    logic [3:0] spec_vec;
    logic       use_spec;
    logic [3:0] recent_vec;
    logic       load_recent;

    modport master (
        output grant_vec, pipe_stall, flush_vec, rollback_e,
        output thr_start, thr_stop, ll_spec_e, ll_nospec_e,
        output spec_hit_vec, spec_miss_vec, done_vec,
        input  req_vec, spec_vec, use_spec, recent_vec, load_recent
    );

    modport slave (
        input  grant_vec, pipe_stall, flush_vec, rollback_e,
        input  thr_start, thr_stop, ll_spec_e, ll_nospec_e,
        input  spec_hit_vec, spec_miss_vec, done_vec,
        output req_vec, spec_vec, use_spec, recent_vec, load_recent
    );
endinterface

// File: rtl/sparc_ifu_thr_pipe_trk.sv
// Per-thread readiness FSMs plus S/D/E thread tracking for the IFU LRU thread select.
// Optional SPEC timeout: define SPARC_IFU_THRTRK_TIMEOUT_EN.
module sparc_ifu_thr_pipe_trk #(
    parameter int TO_W = 4
) (
    input  logic                    clk,
    input  logic                    arst_l,
    sparc_ifu_thr_pipe_trk_if.slave bus
);

    typedef enum logic [1:0] {
        DEAD = 2'd0,
        RDY  = 2'd1,
        SPEC = 2'd2,
        WAIT = 2'd3
    } thr_state_t;

    typedef logic [TO_W-1:0] to_cnt_t;

    logic       vld_s_reg, vld_s_next;
    logic       vld_d_reg, vld_d_next;
    logic       vld_e_reg, vld_e_next;
    logic [3:0] thr_s_reg, thr_s_next;
    logic [3:0] thr_d_reg, thr_d_next;
    logic [3:0] thr_e_reg, thr_e_next;

    logic       grant_kill;
    logic       kill_s;
    logic       kill_d;
    logic       kill_e;
    logic       load_recent;
    logic [3:0] ready_vec;
    logic [3:0] spec_rdy_vec;

    // ---------------- S/D/E thread pipeline ----------------
    assign grant_kill = |(bus.grant_vec & bus.flush_vec);
    assign kill_s     = |(thr_s_reg & bus.flush_vec);
    assign kill_d     = |(thr_d_reg & bus.flush_vec);
    assign kill_e     = (|(thr_e_reg & bus.flush_vec)) | bus.rollback_e;

    always_comb begin
        vld_s_next = vld_s_reg;
        vld_d_next = vld_d_reg;
        vld_e_next = vld_e_reg;
        thr_s_next = thr_s_reg;
        thr_d_next = thr_d_reg;
        thr_e_next = thr_e_reg;
        if (bus.pipe_stall) begin
            // Frozen stages still honour kills so nothing stale survives the stall.
            vld_s_next = vld_s_reg & ~kill_s;
            vld_d_next = vld_d_reg & ~kill_d;
            vld_e_next = vld_e_reg & ~kill_e;
        end else begin
            vld_s_next = (|bus.grant_vec) & ~grant_kill;
            thr_s_next = bus.grant_vec;
            vld_d_next = vld_s_reg & ~kill_s;
            thr_d_next = thr_s_reg;
            vld_e_next = vld_d_reg & ~kill_d;
            thr_e_next = thr_d_reg;
        end
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            vld_s_reg <= 1'b0;
            vld_d_reg <= 1'b0;
            vld_e_reg <= 1'b0;
            thr_s_reg <= 4'b0;
            thr_d_reg <= 4'b0;
            thr_e_reg <= 4'b0;
        end else begin
            vld_s_reg <= vld_s_next;
            vld_d_reg <= vld_d_next;
            vld_e_reg <= vld_e_next;
            thr_s_reg <= thr_s_next;
            thr_d_reg <= thr_d_next;
            thr_e_reg <= thr_e_next;
        end
    end

    // Commit is combinational so the scheduler reorders LRU in the E cycle itself.
    assign load_recent = vld_e_reg & ~bus.rollback_e & ~(|(bus.flush_vec & thr_e_reg))
                       & ~bus.pipe_stall;

    assign bus.recent_vec  = thr_e_reg & {4{vld_e_reg}};
    assign bus.load_recent = load_recent;

    // ---------------- per-thread readiness FSMs ----------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_thr
            thr_state_t state_reg, state_next;
            logic       commit;
            logic       to_expire;

            assign commit = load_recent & thr_e_reg[gi];

`ifdef SPARC_IFU_THRTRK_TIMEOUT_EN
            localparam to_cnt_t TO_SAT = '1;
            to_cnt_t to_cnt_reg, to_cnt_next;

            // Expire on the edge where the count would reach saturation, so the
            // thread spends exactly 2^TO_W-1 cycles in SPEC before falling to WAIT.
            assign to_expire = (state_reg == SPEC) && ((to_cnt_reg + to_cnt_t'(1)) == TO_SAT);

            always_comb begin
                to_cnt_next = to_cnt_reg;
                if (state_reg != SPEC) begin
                    to_cnt_next = '0;
                end else if (to_cnt_reg != TO_SAT) begin
                    to_cnt_next = to_cnt_reg + to_cnt_t'(1);
                end
            end

            always_ff @(posedge clk or negedge arst_l) begin
                if (!arst_l) begin
                    to_cnt_reg <= '0;
                end else begin
                    to_cnt_reg <= to_cnt_next;
                end
            end
`else
            assign to_expire = 1'b0;
`endif

            always_comb begin
                state_next = state_reg;
                if (bus.thr_stop[gi]) begin
                    state_next = DEAD;
                end else begin
                    case (state_reg)
                        DEAD: begin
                            if (bus.thr_start[gi]) state_next = RDY;
                        end
                        RDY: begin
                            if (commit) begin
                                if (bus.ll_nospec_e)    state_next = WAIT;
                                else if (bus.ll_spec_e) state_next = SPEC;
                            end
                        end
                        SPEC: begin
                            if (bus.spec_miss_vec[gi])     state_next = WAIT;
                            else if (bus.spec_hit_vec[gi]) state_next = RDY;
                            else if (to_expire)            state_next = WAIT;
                        end
                        WAIT: begin
                            if (bus.done_vec[gi]) state_next = RDY;
                        end
                        default: state_next = DEAD;
                    endcase
                end
            end

            always_ff @(posedge clk or negedge arst_l) begin
                if (!arst_l) begin
                    state_reg <= DEAD;
                end else begin
                    state_reg <= state_next;
                end
            end

            assign ready_vec[gi]    = (state_reg == RDY);
            assign spec_rdy_vec[gi] = (state_reg == RDY) || (state_reg == SPEC);
        end
    endgenerate

    assign bus.req_vec  = ready_vec;
    assign bus.spec_vec = spec_rdy_vec;
    assign bus.use_spec = ~(|ready_vec) & (|spec_rdy_vec);

    // The scheduler must never grant more than one thread at a time.
    assert property (@(posedge clk) disable iff (!arst_l) $onehot0(bus.grant_vec))
        else $error("sparc_ifu_thr_pipe_trk: multi-hot grant_vec %b", bus.grant_vec);

endmodule
